csr_port_arbiter: RTL and testbench

Shares the single CSR-file access port between the pipeline's EX-stage CSR instructions (core) and an external host/debug requester (e.g. tohost polling, debug writes). Core accesses have priority and issue in the same cycle. A starvation counter guarantees host forward progress. Host requests are latched, issued one cycle after grant, and answered with a registered read response. The block sits between the EX stage and the CSR file and drives the CSR file's we/rd/addr/func/data_in inputs.

---
 rtl/csr_port_arbiter.sv | 121 ++++++++++++
 tb/tb_csr_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_port_arbiter.sv
// Arbitrates the CSR-file access port between EX-stage core accesses (priority)
// and a host/debug requester with starvation-bounded forward progress.
module csr_port_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_we,
  input  logic              core_rd,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [2:0]        core_func,
  input  logic [DWIDTH-1:0] core_wdata,
  output logic              core_rvalid,
  output logic [DWIDTH-1:0] core_rdata,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic              host_we,
  input  logic [AWIDTH-1:0] host_addr,
  input  logic [DWIDTH-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DWIDTH-1:0] host_rdata,
  output logic              csr_we,
  output logic              csr_rd,
  output logic [AWIDTH-1:0] csr_addr,
  output logic [2:0]        csr_func,
  output logic [DWIDTH-1:0] csr_data_in,
  input  logic [DWIDTH-1:0] csr_data_out
);

  localparam logic [2:0] FNC_CSRRW = 3'b001;
  localparam int         CW        = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, H_ISSUE, H_RSP} state_t;

  state_t            state;
  logic [CW-1:0]     wait_cnt;
  logic              starved;
  logic              host_issue;
  logic              h_we;
  logic [AWIDTH-1:0] h_addr;
  logic [DWIDTH-1:0] h_wdata;
  logic [AWIDTH-1:0] last_addr;
  logic [2:0]        last_func;
  logic [DWIDTH-1:0] last_data;

  assign starved    = (wait_cnt == CW'(STARVE_LIMIT));
  assign host_gnt   = rst_n & (state == IDLE) & host_req & (~core_valid | starved);
  assign core_ready = rst_n & core_valid & ~host_gnt & (state != H_ISSUE);
  assign host_issue = rst_n & (state == H_ISSUE);
  assign core_rdata = csr_data_out;

  // core_ready and host_issue are mutually exclusive, so the port never sees both.
  always_comb begin
    csr_we      = 1'b0;
    csr_rd      = 1'b0;
    csr_addr    = last_addr;
    csr_func    = last_func;
    csr_data_in = last_data;
    if (core_ready) begin
      csr_we      = core_we;
      csr_rd      = core_rd;
      csr_addr    = core_addr;
      csr_func    = core_func;
      csr_data_in = core_wdata;
    end else if (host_issue) begin
      csr_we      = h_we;
      csr_rd      = 1'b1;
      csr_addr    = h_addr;
      csr_func    = FNC_CSRRW;
      csr_data_in = h_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      h_we        <= 1'b0;
      h_addr      <= '0;
      h_wdata     <= '0;
      last_addr   <= '0;
      last_func   <= '0;
      last_data   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      core_rvalid <= 1'b0;
    end else begin
      last_addr   <= csr_addr;
      last_func   <= csr_func;
      last_data   <= csr_data_in;
      core_rvalid <= core_ready & core_rd;
      host_rvalid <= (state == H_RSP);
      if (state == H_RSP)
        host_rdata <= csr_data_out;

      if (!host_req || host_gnt)
        wait_cnt <= '0;
      else if (!starved)
        wait_cnt <= wait_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (host_gnt) begin
            state   <= H_ISSUE;
            h_we    <= host_we;
            h_addr  <= host_addr;
            h_wdata <= host_wdata;
          end
        end
        H_ISSUE: state <= H_RSP;
        H_RSP:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_port_arbiter.sv
// Bench for csr_port_arbiter: directed sequences, a cycle vector table and a
// randomized run against a transaction-level reference model with a CSR-file model.
module tb_csr_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_valid, core_ready, core_we, core_rd;
  logic [AW-1:0] core_addr;
  logic [2:0]    core_func;
  logic [DW-1:0] core_wdata;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req, host_gnt, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          csr_we, csr_rd;
  logic [AW-1:0] csr_addr;
  logic [2:0]    csr_func;
  logic [DW-1:0] csr_data_in;
  logic [DW-1:0] csr_data_out;

  always #5 clk = ~clk;

  csr_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_ready(core_ready), .core_we(core_we),
    .core_rd(core_rd), .core_addr(core_addr), .core_func(core_func),
    .core_wdata(core_wdata), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_gnt(host_gnt), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .csr_we(csr_we), .csr_rd(csr_rd),
    .csr_addr(csr_addr), .csr_func(csr_func), .csr_data_in(csr_data_in),
    .csr_data_out(csr_data_out)
  );

  function automatic logic [31:0] csr_apply(input logic [2:0] f, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (f[1:0])
      2'd1:    return wd;
      2'd2:    return old | wd;
      2'd3:    return old & ~wd;
      default: return old;
    endcase
  endfunction

  // CSR file: 16 entries indexed by the low address nibble, registered read.
  logic [31:0] csr_mem [16];
  always @(posedge clk) begin
    if (csr_rd) csr_data_out <= csr_mem[csr_addr[3:0]];
    if (csr_we) csr_mem[csr_addr[3:0]] <= csr_apply(csr_func, csr_mem[csr_addr[3:0]], csr_data_in);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic core_drive(input logic v, input logic we, input logic rd, input logic [AW-1:0] a,
                            input logic [2:0] f, input logic [DW-1:0] wd);
    core_valid = v; core_we = we; core_rd = rd; core_addr = a; core_func = f; core_wdata = wd;
  endtask

  task automatic host_drive(input logic r, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
    host_req = r; host_we = we; host_addr = a; host_wdata = wd;
  endtask

  typedef struct {
    logic cv, hreq;
    logic e_ready, e_gnt, e_rd, e_we;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic cv, input logic hreq, input logic e_ready,
                     input logic e_gnt, input logic e_rd, input logic e_we);
    vec_t v;
    v.cv = cv; v.hreq = hreq; v.e_ready = e_ready; v.e_gnt = e_gnt; v.e_rd = e_rd; v.e_we = e_we;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  logic [AW-1:0] addrs [4] = '{12'h300, 12'h341, 12'h342, 12'h51E};
  logic [2:0]    funcs [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ref_mem [16];
    int cyc, last_gnt, waited, phase;
    logic e_gnt, e_ready, e_rd, e_we, hreq_on, lh_we;
    logic [AW-1:0] lh_addr, e_addr;
    logic [DW-1:0] lh_wdata, e_hrd, e_crd, nxt_crd, e_din, old;
    logic [2:0] e_func;
    logic e_crv;
    logic [3:0] a;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    core_drive(1'b1, 1'b1, 1'b1, 12'h51E, 3'd1, 32'h1);
    host_drive(1'b1, 1'b1, 12'h51E, 32'h1);
    @(negedge clk); #1;
    chk("rst_host_gnt", 32'(host_gnt), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    chk("rst_csr_rd", 32'(csr_rd), 32'd0);
    chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_host_rdata", host_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    core_drive(1'b0, 1'b0, 1'b0, 12'h0, 3'd0, 32'h0);
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);

    // ---------------- core only ----------------
    @(negedge clk);
    core_drive(1'b1, 1'b1, 1'b0, 12'h51E, 3'd1, 32'h12);
    #1;
    chk("core_wr_ready", 32'(core_ready), 32'd1);
    chk("core_wr_csr_we", 32'(csr_we), 32'd1);
    chk("core_wr_din", csr_data_in, 32'h12);
    @(negedge clk);
    core_drive(1'b1, 1'b1, 1'b0, 12'h300, 3'd1, 32'hA5A5);
    #1;
    chk("core_wr2_ready", 32'(core_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_drive(1'b1, 1'b0, 1'b1, 12'h51E, 3'd2, 32'h0);
      #1;
      chk("core_rd_ready", 32'(core_ready), 32'd1);
      chk("core_rd_csr_rd", 32'(csr_rd), 32'd1);
      chk("core_rd_addr", 32'(csr_addr), 32'h51E);
      chk("core_rd_gnt", 32'(host_gnt), 32'd0);
      if (i > 0) begin
        chk("core_rvalid", 32'(core_rvalid), 32'd1);
        chk("core_rdata", core_rdata, 32'h12);
      end
    end
    @(negedge clk);
    core_drive(1'b0, 1'b0, 1'b0, 12'h0, 3'd0, 32'h0);
    #1;
    chk("core_rvalid_last", 32'(core_rvalid), 32'd1);
    chk("core_rdata_last", core_rdata, 32'h12);
    chk("idle_csr_rd", 32'(csr_rd), 32'd0);
    @(negedge clk); #1;
    chk("core_rvalid_off", 32'(core_rvalid), 32'd0);

    // ---------------- host only ----------------
    @(negedge clk);
    host_drive(1'b1, 1'b1, 12'h51E, 32'hDEADBEEF);
    #1;
    chk("host_gnt_G", 32'(host_gnt), 32'd1);
    @(negedge clk);
    host_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("host_G1_csr_we", 32'(csr_we), 32'd1);
    chk("host_G1_csr_rd", 32'(csr_rd), 32'd1);
    chk("host_G1_din", csr_data_in, 32'hDEADBEEF);
    chk("host_G1_func", 32'(csr_func), 32'd1);
    chk("host_G1_addr", 32'(csr_addr), 32'h51E);
    @(negedge clk); #1;
    chk("host_G2_rvalid", 32'(host_rvalid), 32'd0);
    chk("host_G2_csr_we", 32'(csr_we), 32'd0);
    @(negedge clk); #1;
    chk("host_G3_rvalid", 32'(host_rvalid), 32'd1);
    chk("host_G3_rdata", host_rdata, 32'h12);
    @(negedge clk); #1;
    chk("host_G4_rvalid", 32'(host_rvalid), 32'd0);

    // ---------------- contention / early withdraw table ----------------
    add(8, 1, 1, 1, 0, 1, 0);  // host waits STARVE_LIMIT cycles under core load
    add(1, 1, 1, 0, 1, 0, 0);  // grant, core stalls
    add(1, 1, 0, 0, 0, 1, 0);  // host issue (read), core stalls
    add(2, 1, 0, 1, 0, 1, 0);  // H_RSP and idle: core flows
    add(3, 1, 1, 1, 0, 1, 0);  // host request then withdraw
    add(1, 1, 0, 1, 0, 1, 0);
    add(8, 1, 1, 1, 0, 1, 0);  // full wait needed again
    add(1, 1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    add(2, 1, 0, 1, 0, 1, 0);
    host_we = 1'b0; host_addr = 12'h342; host_wdata = 32'h0;
    foreach (vecs[i]) begin
      @(negedge clk);
      core_drive(vecs[i].cv, 1'b0, 1'b1, 12'h341, 3'd2, 32'h0);
      host_req = vecs[i].hreq;
      #1;
      chk($sformatf("vec%0d_core_ready", i), 32'(core_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_host_gnt", i), 32'(host_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_csr_rd", i), 32'(csr_rd), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_csr_we", i), 32'(csr_we), 32'(vecs[i].e_we));
    end
    @(negedge clk);
    core_drive(1'b0, 1'b0, 1'b0, 12'h0, 3'd0, 32'h0);
    host_req = 1'b0;
    @(negedge clk);

    // ---------------- overlap in H_RSP ----------------
    @(negedge clk);
    host_drive(1'b1, 1'b0, 12'h51E, 32'h0);
    #1;
    chk("ovl_gnt", 32'(host_gnt), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    core_drive(1'b1, 1'b0, 1'b1, 12'h300, 3'd2, 32'h0);
    #1;
    chk("ovl_core_ready", 32'(core_ready), 32'd1);
    @(negedge clk);
    core_drive(1'b0, 1'b0, 1'b0, 12'h0, 3'd0, 32'h0);
    #1;
    chk("ovl_core_rvalid", 32'(core_rvalid), 32'd1);
    chk("ovl_core_rdata", core_rdata, 32'hA5A5);
    chk("ovl_host_rvalid", 32'(host_rvalid), 32'd1);
    chk("ovl_host_rdata", host_rdata, 32'hDEADBEEF);

    // ---------------- reset in H_ISSUE ----------------
    @(negedge clk);
    host_drive(1'b1, 1'b1, 12'h300, 32'h777);
    #1;
    chk("mid_gnt", 32'(host_gnt), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_csr_we", 32'(csr_we), 32'd0);
    chk("mid_csr_rd", 32'(csr_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("mid_no_rvalid", 32'(host_rvalid), 32'd0);
      chk("mid_no_gnt", 32'(host_gnt), 32'd0);
      chk("mid_no_csr_rd", 32'(csr_rd), 32'd0);
    end
    chk("mid_mem_untouched", csr_mem[0], 32'hA5A5);
    @(negedge clk);
    host_drive(1'b1, 1'b0, 12'h300, 32'h0);
    #1;
    chk("mid_regrant", 32'(host_gnt), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("mid_rvalid", 32'(host_rvalid), 32'd1);
    chk("mid_rdata", host_rdata, 32'hA5A5);
    @(negedge clk);

    // ---------------- randomized run vs. reference model ----------------
    foreach (csr_mem[i]) ref_mem[i] = csr_mem[i];
    cyc = 0; last_gnt = -100; waited = 0; hreq_on = 1'b0;
    e_crv = 1'b0; e_crd = '0; e_hrd = '0; lh_we = 1'b0; lh_addr = '0; lh_wdata = '0;
    e_gnt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hreq_on && e_gnt) hreq_on = 1'b0;
      else if (hreq_on && $urandom_range(0, 39) == 0) hreq_on = 1'b0;
      else if (!hreq_on && $urandom_range(0, 3) == 0) begin
        hreq_on = 1'b1;
        host_drive(1'b1, 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], $urandom);
      end
      host_req = hreq_on;
      core_drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)],
                 funcs[$urandom_range(0, 5)], $urandom);
      #1;
      phase   = cyc - last_gnt;
      e_gnt   = (phase >= 3) && host_req && (!core_valid || waited >= SL);
      e_ready = core_valid && !e_gnt && (phase != 1);
      e_rd = 1'b0; e_we = 1'b0; e_addr = '0; e_func = '0; e_din = '0;
      if (e_ready) begin
        e_rd = core_rd; e_we = core_we; e_addr = core_addr; e_func = core_func; e_din = core_wdata;
      end else if (phase == 1) begin
        e_rd = 1'b1; e_we = lh_we; e_addr = lh_addr; e_func = 3'd1; e_din = lh_wdata;
      end
      chk("rnd_core_ready", 32'(core_ready), 32'(e_ready));
      chk("rnd_host_gnt", 32'(host_gnt), 32'(e_gnt));
      chk("rnd_csr_rd", 32'(csr_rd), 32'(e_rd));
      chk("rnd_csr_we", 32'(csr_we), 32'(e_we));
      if (e_rd || e_we) begin
        chk("rnd_csr_addr", 32'(csr_addr), 32'(e_addr));
        chk("rnd_csr_func", 32'(csr_func), 32'(e_func));
        chk("rnd_csr_din", csr_data_in, e_din);
      end
      chk("rnd_core_rvalid", 32'(core_rvalid), 32'(e_crv));
      if (e_crv) chk("rnd_core_rdata", core_rdata, e_crd);
      chk("rnd_host_rvalid", 32'(host_rvalid), 32'(phase == 3));
      if (phase == 3) chk("rnd_host_rdata", host_rdata, e_hrd);

      nxt_crd = e_crd;
      if (e_rd || e_we) begin
        a = e_addr[3:0];
        old = ref_mem[a];
        if (e_ready && core_rd) nxt_crd = old;
        if (!e_ready) e_hrd = old;
        if (e_we) ref_mem[a] = csr_apply(e_func, old, e_din);
      end
      e_crv = e_ready && core_rd;
      e_crd = nxt_crd;
      if (!host_req || e_gnt) waited = 0;
      else if (waited < SL) waited++;
      if (e_gnt) begin
        last_gnt = cyc; lh_we = host_we; lh_addr = host_addr; lh_wdata = host_wdata;
      end
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
